// File: rtl/cam_pattern_tx_pkg.sv
// Shared definitions for the synthetic camera transmitter.
// Contains the FSM state encoding, the pattern selector encoding and the RGB565 colour constants.
package cam_pattern_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_e;

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_e;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;

    // Colour-bar table, left to right across the line
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_pattern_tx_if.sv
// Camera-side signal bundle: control inputs plus the OV7670-style output stream.
// The master modport is the transmitter; the slave modport is the capture side.
interface cam_pattern_tx_if;
    logic        i_en;
    logic [1:0]  i_pattern_sel;
    logic [15:0] i_solid_color;
    logic        o_pclk;
    logic        o_vsync;
    logic        o_href;
    logic [7:0]  o_data;
    logic        o_frame_done;
    logic        o_busy;

    modport master (
        input  i_en, i_pattern_sel, i_solid_color,
        output o_pclk, o_vsync, o_href, o_data, o_frame_done, o_busy
    );

    modport slave (
        output i_en, i_pattern_sel, i_solid_color,
        input  o_pclk, o_vsync, o_href, o_data, o_frame_done, o_busy
    );
endinterface

// File: rtl/cam_pattern_gen.sv
// Combinational RGB565 pixel colour for the current (x, y) position and selected pattern.
// Only x[7:3] and y[7:2] matter to any pattern, so only those bits are passed in.
module cam_pattern_gen
    import cam_pattern_tx_pkg::*;
(
    input  logic [4:0]  i_x_hi,
    input  logic [5:0]  i_y_hi,
    input  logic [2:0]  i_bar_idx,
    input  pattern_e    i_pattern,
    input  logic [15:0] i_solid,
    output logic [15:0] o_pixel
);

    always_comb begin
        o_pixel = BLACK;
        case (i_pattern)
            PAT_SOLID:    o_pixel = i_solid;
            PAT_BARS:     o_pixel = bar_color(i_bar_idx);
            // x[3] is i_x_hi[0], y[3] is i_y_hi[1]
            PAT_CHECKER:  o_pixel = (i_x_hi[0] ^ i_y_hi[1]) ? BLACK : WHITE;
            PAT_GRADIENT: o_pixel = {i_x_hi, i_y_hi, 5'b00000};
            default:      o_pixel = BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_tx.sv
// Synthetic OV7670-style transmitter: PCLK = clk/2, VSYNC/HREF/DATA change on PCLK falling edges.
// Optional macro CAM_TX_FRAME_CNT_EN replaces pixel (0,0) with an 8-bit frame counter.
module cam_pattern_tx
    import cam_pattern_tx_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int HBLANK        = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int VBP_LINES     = 17,
    parameter int VFP_LINES     = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    cam_pattern_tx_if.master cam
);

    localparam int ACTIVE_PCLKS = 2 * SCREEN_WIDTH;
    localparam int LINE_PCLKS   = ACTIVE_PCLKS + HBLANK;
    localparam int BAR_W        = SCREEN_WIDTH / 8;
    localparam int HW           = $clog2(LINE_PCLKS);
    localparam int LW           = $clog2(SCREEN_HEIGHT + VSYNC_LINES + VBP_LINES + VFP_LINES + 1);

    state_e      r_state;
    state_e      w_next_state;
    logic        r_pclk;
    logic [HW-1:0] r_hcnt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] w_last_line;
    logic [7:0]  r_bar_cnt;
    logic [2:0]  r_bar_idx;
    pattern_e    r_pattern;
    logic [15:0] r_solid;
    logic        w_tick;
    logic        w_end_line;
    logic        w_end_state;
    logic        w_frame_done;
    logic        w_href;
    logic        w_pixel_end;
    logic        w_latch;
    logic [15:0] w_pixel;
    logic [7:0]  w_byte;

    // A tick is the cycle in which PCLK is about to fall
    assign w_tick      = r_pclk;
    assign w_end_line  = (r_hcnt == HW'(LINE_PCLKS - 1));
    assign w_href      = (r_state == ST_ACTIVE) && (r_hcnt < HW'(ACTIVE_PCLKS));
    assign w_pixel_end = w_href && r_hcnt[0];
    assign w_end_state = w_tick && w_end_line && (r_lcnt == w_last_line);
    assign w_latch     = w_tick && (w_next_state == ST_VSYNC) && (r_state != ST_VSYNC);

    always_comb begin
        w_last_line = '0;
        case (r_state)
            ST_VSYNC:  w_last_line = LW'(VSYNC_LINES - 1);
            ST_VBP:    w_last_line = LW'(VBP_LINES - 1);
            ST_ACTIVE: w_last_line = LW'(SCREEN_HEIGHT - 1);
            ST_VFP:    w_last_line = LW'(VFP_LINES - 1);
            default:   w_last_line = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_tick && cam.i_en) w_next_state = ST_VSYNC;
            ST_VSYNC:  if (w_end_state) w_next_state = ST_VBP;
            ST_VBP:    if (w_end_state) w_next_state = ST_ACTIVE;
            ST_ACTIVE: if (w_end_state) w_next_state = ST_VFP;
            ST_VFP: begin
                if (w_end_state) begin
                    w_frame_done = 1'b1;
                    w_next_state = cam.i_en ? ST_VSYNC : ST_IDLE;
                end
            end
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bar index advances via a per-bar pixel counter so no divider is needed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pclk    <= 1'b0;
            r_hcnt    <= '0;
            r_lcnt    <= '0;
            r_bar_cnt <= 8'd0;
            r_bar_idx <= 3'd0;
            r_pattern <= PAT_SOLID;
            r_solid   <= 16'h0000;
        end else begin
            r_pclk <= ~r_pclk;
            if (w_tick) begin
                if (r_state == ST_IDLE || w_end_line) begin
                    r_hcnt <= '0;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
                if (r_state == ST_IDLE || w_end_state) begin
                    r_lcnt <= '0;
                end else if (w_end_line) begin
                    r_lcnt <= r_lcnt + 1'b1;
                end
                if (r_state == ST_IDLE || w_end_line) begin
                    r_bar_cnt <= 8'd0;
                    r_bar_idx <= 3'd0;
                end else if (w_pixel_end) begin
                    if (r_bar_cnt == 8'(BAR_W - 1)) begin
                        r_bar_cnt <= 8'd0;
                        r_bar_idx <= r_bar_idx + 3'd1;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + 8'd1;
                    end
                end
            end
            if (w_latch) begin
                r_pattern <= pattern_e'(cam.i_pattern_sel);
                r_solid   <= cam.i_solid_color;
            end
        end
    end

    cam_pattern_gen u_gen (
        .i_x_hi    (5'(r_hcnt >> 4)),
        .i_y_hi    (6'(r_lcnt >> 2)),
        .i_bar_idx (r_bar_idx),
        .i_pattern (r_pattern),
        .i_solid   (r_solid),
        .o_pixel   (w_pixel)
    );

`ifdef CAM_TX_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    always_comb begin
        w_byte = r_hcnt[0] ? w_pixel[7:0] : w_pixel[15:8];
        if (r_lcnt == '0 && r_hcnt < HW'(2)) w_byte = r_frame_cnt;
    end
`else
    assign w_byte = r_hcnt[0] ? w_pixel[7:0] : w_pixel[15:8];
`endif

    assign cam.o_pclk       = r_pclk;
    assign cam.o_vsync      = (r_state == ST_VSYNC);
    assign cam.o_href       = w_href;
    assign cam.o_data       = w_href ? w_byte : 8'h00;
    assign cam.o_frame_done = w_frame_done;
    assign cam.o_busy       = (r_state != ST_IDLE);

endmodule
